// File: rtl/jump_control_sequencer.sv
// Hardwired fetch/execute control for the jr/jal/nop/halt opcode class.
// Adds memory-ready wait with timeout, retired counter and sticky halt/fault.
module jump_control_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter logic [OPCODE_WIDTH-1:0] OP_JR   = 5'b10100,
  parameter logic [OPCODE_WIDTH-1:0] OP_JAL  = 5'b10011,
  parameter logic [OPCODE_WIDTH-1:0] OP_NOP  = 5'b11010,
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT = 5'b11011,
  parameter int WAIT_MAX     = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Run,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  Mem_ready,
  output logic                  PCout,
  output logic                  MAR_enable,
  output logic                  IncPC,
  output logic                  ZLowIn,
  output logic                  ZLowout,
  output logic                  PC_enable,
  output logic                  MDR_read,
  output logic                  MDR_enable,
  output logic                  MDRout,
  output logic                  IR_enable,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  R_in,
  output logic                  R_out,
  output logic                  Busy,
  output logic                  Halted,
  output logic                  Fault,
  output logic [CNT_WIDTH-1:0]  Retired
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_HALT,
    S_FAULT
  } state_t;

  state_t                  state;
  logic [WW-1:0]           wait_cnt;
  logic [CNT_WIDTH-1:0]    retired;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    is_jr;
  logic                    is_jal;
  logic                    is_nop;
  logic                    is_halt;
  logic                    instr_end;
  logic                    unused_ir;

  assign opcode  = IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign is_jr   = (opcode == OP_JR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);

  // Operand fields are routed by the datapath's own select logic.
  assign unused_ir = ^IR[DATA_WIDTH-OPCODE_WIDTH-1:0];

  assign instr_end = ((state == S_T3) && (is_jr || is_nop))
                   || (state == S_T4);

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      if (instr_end && !(&retired))
        retired <= retired + CNT_WIDTH'(1);
      unique case (state)
        S_IDLE: begin
          if (Run)
            state <= S_T0;
        end
        S_T0: begin
          wait_cnt <= '0;
          state    <= S_T1;
        end
        S_T1: begin
          if (Mem_ready)
            state <= S_T2;
          else if (wait_cnt == WLAST)
            state <= S_FAULT;
          else
            wait_cnt <= wait_cnt + WW'(1);
        end
        S_T2: state <= S_T3;
        S_T3: begin
          unique case (1'b1)
            is_jr, is_nop: state <= Run ? S_T0 : S_IDLE;
            is_jal:        state <= S_T4;
            is_halt:       state <= S_HALT;
            default:       state <= S_FAULT;
          endcase
        end
        S_T4: state <= Run ? S_T0 : S_IDLE;
        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  assign Retired = retired;

  always_comb begin
    PCout      = 1'b0;
    MAR_enable = 1'b0;
    IncPC      = 1'b0;
    ZLowIn     = 1'b0;
    ZLowout    = 1'b0;
    PC_enable  = 1'b0;
    MDR_read   = 1'b0;
    MDR_enable = 1'b0;
    MDRout     = 1'b0;
    IR_enable  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    R_in       = 1'b0;
    R_out      = 1'b0;
    unique case (state)
      S_T0: begin
        PCout      = 1'b1;
        MAR_enable = 1'b1;
        IncPC      = 1'b1;
        ZLowIn     = 1'b1;
      end
      S_T1: begin
        MDR_read   = 1'b1;
        MDR_enable = 1'b1;
        ZLowout    = Mem_ready;
        PC_enable  = Mem_ready;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_jr: begin
            Gra       = 1'b1;
            R_out     = 1'b1;
            PC_enable = 1'b1;
          end
          is_jal: begin
            PCout = 1'b1;
            Grb   = 1'b1;
            R_in  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        Gra       = 1'b1;
        R_out     = 1'b1;
        PC_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy   = !(state inside {S_IDLE, S_HALT, S_FAULT});
  assign Halted = (state == S_HALT);
  assign Fault  = (state == S_FAULT);

endmodule

// File: tb/tb_jump_control_sequencer.sv
// Bench for jump_control_sequencer: expected per-cycle enable traces
// are built from instruction-level rules and replayed against the DUT.
module tb_jump_control_sequencer;

  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [16:0] PCO  = 17'h10000;
  localparam logic [16:0] MAR  = 17'h08000;
  localparam logic [16:0] INC  = 17'h04000;
  localparam logic [16:0] ZIN  = 17'h02000;
  localparam logic [16:0] ZOUT = 17'h01000;
  localparam logic [16:0] PCE  = 17'h00800;
  localparam logic [16:0] MRD  = 17'h00400;
  localparam logic [16:0] MDE  = 17'h00200;
  localparam logic [16:0] MDO  = 17'h00100;
  localparam logic [16:0] IRE  = 17'h00080;
  localparam logic [16:0] GRA  = 17'h00040;
  localparam logic [16:0] GRB  = 17'h00020;
  localparam logic [16:0] RIN  = 17'h00010;
  localparam logic [16:0] ROUT = 17'h00008;
  localparam logic [16:0] BSY  = 17'h00004;
  localparam logic [16:0] HLT  = 17'h00002;
  localparam logic [16:0] FLT  = 17'h00001;

  localparam logic [16:0] V_T0 = PCO | MAR | INC | ZIN | BSY;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        Run = 1'b0;
  logic        Mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic        PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable;
  logic        MDR_read, MDR_enable, MDRout, IR_enable;
  logic        Gra, Grb, R_in, R_out, Busy, Halted, Fault;
  logic [15:0] Retired;
  logic [16:0] obs;

  logic        run2 = 1'b0;
  logic        mem2 = 1'b0;
  logic [31:0] ir2 = '0;
  logic [16:0] obs2;
  logic [1:0]  retired2;

  int checks = 0;
  int failures = 0;
  int model_ret = 0;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [16:0] vec;
    int          ret;
  } step_t;

  step_t q[$];

  always #5 Clock = ~Clock;

  jump_control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
    .Mem_ready(Mem_ready),
    .PCout(PCout), .MAR_enable(MAR_enable), .IncPC(IncPC),
    .ZLowIn(ZLowIn), .ZLowout(ZLowout), .PC_enable(PC_enable),
    .MDR_read(MDR_read), .MDR_enable(MDR_enable), .MDRout(MDRout),
    .IR_enable(IR_enable), .Gra(Gra), .Grb(Grb), .R_in(R_in),
    .R_out(R_out), .Busy(Busy), .Halted(Halted), .Fault(Fault),
    .Retired(Retired)
  );

  assign obs = {PCout, MAR_enable, IncPC, ZLowIn, ZLowout, PC_enable,
                MDR_read, MDR_enable, MDRout, IR_enable, Gra, Grb,
                R_in, R_out, Busy, Halted, Fault};

  jump_control_sequencer #(.CNT_WIDTH(2)) dut_small (
    .Clock(Clock), .Clear(Clear), .Run(run2), .IR(ir2),
    .Mem_ready(mem2),
    .PCout(obs2[16]), .MAR_enable(obs2[15]), .IncPC(obs2[14]),
    .ZLowIn(obs2[13]), .ZLowout(obs2[12]), .PC_enable(obs2[11]),
    .MDR_read(obs2[10]), .MDR_enable(obs2[9]), .MDRout(obs2[8]),
    .IR_enable(obs2[7]), .Gra(obs2[6]), .Grb(obs2[5]), .R_in(obs2[4]),
    .R_out(obs2[3]), .Busy(obs2[2]), .Halted(obs2[1]), .Fault(obs2[0]),
    .Retired(retired2)
  );

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(logic run, logic mr,
                               logic [31:0] ir, logic [16:0] v);
    step_t s;
    s.run = run;
    s.mr  = mr;
    s.ir  = ir;
    s.vec = v;
    s.ret = model_ret;
    q.push_back(s);
  endfunction

  function automatic logic [31:0] mk_ir(logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  // Fetch: T0, `waits` stalled T1 cycles, the ready T1 cycle, then T2.
  function automatic void add_fetch(logic [31:0] ir, int waits);
    push(rb(), rb(), ir, V_T0);
    for (int i = 0; i < waits; i++)
      push(rb(), 1'b0, ir, MRD | MDE | BSY);
    push(rb(), 1'b1, ir, MRD | MDE | ZOUT | PCE | BSY);
    push(rb(), rb(), ir, MDO | IRE | BSY);
  endfunction

  // Whole retiring instruction; Run is only meaningful on its last cycle.
  function automatic void add_instr(logic [4:0] op, int waits,
                                    logic end_run);
    logic [31:0] ir;
    ir = mk_ir(op);
    add_fetch(ir, waits);
    if (op == OP_JR) begin
      push(end_run, rb(), ir, GRA | ROUT | PCE | BSY);
    end else if (op == OP_JAL) begin
      push(rb(), rb(), ir, PCO | GRB | RIN | BSY);
      push(end_run, rb(), ir, GRA | ROUT | PCE | BSY);
    end else begin
      push(end_run, rb(), ir, BSY);
    end
    if (model_ret < 65535)
      model_ret++;
  endfunction

  function automatic void add_idle(logic run);
    push(run, rb(), 32'($urandom), 17'h0);
  endfunction

  task automatic do_reset();
    q.delete();
    model_ret = 0;
    @(negedge Clock);
    Clear = 1'b0;
    Run = 1'b0;
    Mem_ready = 1'b0;
    repeat (2) @(negedge Clock);
    Clear = 1'b1;
  endtask

  task automatic test_reset();
    #2 Clear = 1'b0;
    @(negedge Clock);
    #1;
    checks++;
    if (obs !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want %b", obs, 17'h0);
    end
    checks++;
    if (Retired !== 16'd0) begin
      failures++;
      $display("FAIL reset_retired: got %0d want 0", Retired);
    end
    checks++;
    if (retired2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_retired_small: got %0d want 0", retired2);
    end
    Clear = 1'b1;
  endtask

  task automatic test_jr_jal_nop();
    do_reset();
    add_idle(1'b1);
    add_instr(OP_JR, 0, 1'b1);
    add_instr(OP_JAL, 0, 1'b1);
    add_instr(OP_NOP, 0, 1'b0);
    add_idle(1'b0);
    add_idle(1'b0);
    foreach (q[i]) begin
      @(negedge Clock);
      Run = q[i].run;
      Mem_ready = q[i].mr;
      IR = q[i].ir;
      #1;
      checks++;
      if (obs !== q[i].vec) begin
        failures++;
        $display("FAIL jr_jal_nop step %0d: got %b want %b",
                 i, obs, q[i].vec);
      end
      checks++;
      if (Retired !== 16'(q[i].ret)) begin
        failures++;
        $display("FAIL jr_jal_nop_retired step %0d: got %0d want %0d",
                 i, Retired, q[i].ret);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] ir;
    do_reset();
    add_idle(1'b1);
    add_instr(OP_JR, 2, 1'b1);
    add_instr(OP_NOP, 3, 1'b1);
    add_instr(OP_JAL, 1, 1'b0);
    add_idle(1'b0);
    add_idle(1'b1);
    ir = mk_ir(OP_JR);
    push(1'b1, rb(), ir, V_T0);
    for (int i = 0; i < 4; i++)
      push(1'b1, 1'b0, ir, MRD | MDE | BSY);
    for (int i = 0; i < 6; i++)
      push(1'b1, rb(), ir, FLT);
    foreach (q[i]) begin
      @(negedge Clock);
      Run = q[i].run;
      Mem_ready = q[i].mr;
      IR = q[i].ir;
      #1;
      checks++;
      if (obs !== q[i].vec) begin
        failures++;
        $display("FAIL mem_wait step %0d: got %b want %b",
                 i, obs, q[i].vec);
      end
      checks++;
      if (Retired !== 16'(q[i].ret)) begin
        failures++;
        $display("FAIL mem_wait_retired step %0d: got %0d want %0d",
                 i, Retired, q[i].ret);
      end
    end
  endtask

  task automatic test_halt_fault();
    logic [4:0]  op;
    logic [31:0] ir;
    for (int c = 0; c < 3; c++) begin
      do_reset();
      if (c == 0) op = OP_HALT;
      else if (c == 1) op = 5'b00000;
      else
        do op = 5'($urandom);
        while (op inside {OP_JR, OP_JAL, OP_NOP, OP_HALT});
      ir = mk_ir(op);
      add_idle(1'b1);
      add_fetch(ir, $urandom_range(0, 3));
      push(1'b1, rb(), ir, BSY);
      for (int i = 0; i < 20; i++)
        push(1'b1, rb(), mk_ir(OP_JR), (c == 0) ? HLT : FLT);
      foreach (q[i]) begin
        @(negedge Clock);
        Run = q[i].run;
        Mem_ready = q[i].mr;
        IR = q[i].ir;
        #1;
        checks++;
        if (obs !== q[i].vec) begin
          failures++;
          $display("FAIL halt_fault op=%b step %0d: got %b want %b",
                   op, i, obs, q[i].vec);
        end
        checks++;
        if (Retired !== 16'(q[i].ret)) begin
          failures++;
          $display("FAIL halt_fault_retired step %0d: got %0d want %0d",
                   i, Retired, q[i].ret);
        end
      end
    end
  endtask

  task automatic test_clear_async();
    do_reset();
    add_idle(1'b1);
    add_instr(OP_JR, 0, 1'b1);
    add_fetch(mk_ir(OP_JAL), 1);
    foreach (q[i]) begin
      @(negedge Clock);
      Run = q[i].run;
      Mem_ready = q[i].mr;
      IR = q[i].ir;
      #1;
      checks++;
      if (obs !== q[i].vec || Retired !== 16'(q[i].ret)) begin
        failures++;
        $display("FAIL clear_setup step %0d: got %b/%0d want %b/%0d",
                 i, obs, Retired, q[i].vec, q[i].ret);
      end
    end
    #2 Clear = 1'b0;
    #1;
    checks++;
    if (obs !== 17'h0 || Retired !== 16'd0) begin
      failures++;
      $display("FAIL clear_async: got %b/%0d want %b/0",
               obs, Retired, 17'h0);
    end
    @(negedge Clock);
    Clear = 1'b1;
    Run = 1'b1;
    #1;
    checks++;
    if (obs !== 17'h0) begin
      failures++;
      $display("FAIL clear_release_idle: got %b want %b", obs, 17'h0);
    end
    @(negedge Clock);
    #1;
    checks++;
    if (obs !== V_T0) begin
      failures++;
      $display("FAIL clear_release_t0: got %b want %b", obs, V_T0);
    end
    Run = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    logic       er;
    do_reset();
    add_idle(1'b1);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: op = OP_JR;
        1: op = OP_JAL;
        default: op = OP_NOP;
      endcase
      er = (n != 39) && ($urandom_range(0, 3) != 0);
      add_instr(op, $urandom_range(0, 3), er);
      if (!er) begin
        for (int k = $urandom_range(0, 2); k > 0; k--)
          add_idle(1'b0);
        add_idle(n != 39);
      end
    end
    foreach (q[i]) begin
      @(negedge Clock);
      Run = q[i].run;
      Mem_ready = q[i].mr;
      IR = q[i].ir;
      #1;
      checks++;
      if (obs !== q[i].vec) begin
        failures++;
        $display("FAIL back_to_back step %0d: got %b want %b",
                 i, obs, q[i].vec);
      end
      checks++;
      if (Retired !== 16'(q[i].ret)) begin
        failures++;
        $display("FAIL back_to_back_retired step %0d: got %0d want %0d",
                 i, Retired, q[i].ret);
      end
    end
  endtask

  // Each nop takes four cycles; the count is visible at the next T0.
  task automatic test_saturate();
    int k;
    int exp;
    do_reset();
    for (int s = 0; s < 22; s++) begin
      @(negedge Clock);
      run2 = 1'b1;
      mem2 = 1'b1;
      ir2 = mk_ir(OP_NOP);
      #1;
      if (s >= 5 && ((s - 1) % 4) == 0) begin
        k = (s - 5) / 4;
        exp = (k + 1 > 3) ? 3 : k + 1;
        checks++;
        if (retired2 !== 2'(exp) || obs2 !== V_T0) begin
          failures++;
          $display("FAIL saturate nop %0d: got %0d/%b want %0d/%b",
                   k, retired2, obs2, exp, V_T0);
        end
      end
    end
    run2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jr_jal_nop();
    test_mem_wait();
    test_halt_fault();
    test_clear_async();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
